// File: rtl/alu_arb_pkg.sv
// Shared widths, FSM encoding and requester-id type for the two-requester
// ALU arbiter.
package alu_arb_pkg;

    localparam int OC_W = 3;
    localparam int D_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way arbiter: a lone requester always wins; under
// contention, fixed priority favours requester 0, round-robin favours the
// requester that was not granted last.
module arb_pick
    import alu_arb_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  req_id_t last,
    input  logic    prio_mode,
    output logic    any,
    output req_id_t winner
);

    always_comb begin
        any    = req0 | req1;
        winner = 1'b0;
        if (req0 && req1)
            winner = prio_mode ? 1'b0 : ~last;
        else if (req1)
            winner = 1'b1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters. Each
// operation takes two cycles: grant and operand launch, then result capture.
//
//   state | meaning
//   IDLE  | sampling requests; no operation in flight
//   EXEC  | operands on alu_*, gnt high; alu_f captured on the next edge
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            prio_mode,
    input  logic            req0,
    input  logic            req1,
    input  logic [OC_W-1:0] oc0,
    input  logic [OC_W-1:0] oc1,
    input  logic [D_W-1:0]  a0,
    input  logic [D_W-1:0]  a1,
    input  logic [D_W-1:0]  b0,
    input  logic [D_W-1:0]  b1,
    output logic            gnt0,
    output logic            gnt1,
    output logic [OC_W-1:0] alu_oc,
    output logic [D_W-1:0]  alu_a,
    output logic [D_W-1:0]  alu_b,
    input  logic [D_W-1:0]  alu_f,
    output logic            res_valid,
    output logic            res_id,
    output logic [D_W-1:0]  res_f,
    output logic            busy
);

    state_t  state;
    req_id_t last;
    logic    any;
    req_id_t winner;

    arb_pick u_pick (
        .req0      (req0),
        .req1      (req1),
        .last      (last),
        .prio_mode (prio_mode),
        .any       (any),
        .winner    (winner)
    );

    // last resets to 1 so requester 0 wins the first contested round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            alu_oc    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_f     <= '0;
        end else if (state == IDLE) begin
            res_valid <= 1'b0;
            if (any) begin
                state <= EXEC;
                last  <= winner;
                gnt0  <= ~winner;
                gnt1  <= winner;
                if (winner) begin
                    alu_oc <= oc1;
                    alu_a  <= a1;
                    alu_b  <= b1;
                end else begin
                    alu_oc <= oc0;
                    alu_a  <= a0;
                    alu_b  <= b0;
                end
            end
        end else begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            res_f     <= alu_f;
            res_valid <= 1'b1;
            res_id    <= last;
        end
    end

    assign busy = (state == EXEC);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (requester 0 wins)
- req0, req1  input  1 each  requester operation request
- oc0, oc1  input  3 each  requester ALU opcode
- a0, a1  input  4 each  requester operand A
- b0, b1  input  4 each  requester operand B
- gnt0, gnt1  output  1 each  grant; one-cycle pulse
- alu_oc  output  3  opcode to the shared ALU
- alu_a, alu_b  output  4 each  operands to the shared ALU
- alu_f  input  4  combinational ALU result
- res_valid  output  1  result strobe; one-cycle pulse
- res_id  output  1  requester that owns res_f
- res_f  output  4  captured ALU result
- busy  output  1  high while an operation is in flight

Function
REQ-002 The FSM SHALL have two states: IDLE and EXEC.
REQ-003 Requests SHALL be sampled only in IDLE; req lines are ignored in EXEC.
REQ-004 On an edge in IDLE with at least one req high, the block SHALL:
- enter EXEC;
- register the winner's oc/a/b onto alu_oc/alu_a/alu_b;
- set that winner's gnt high and record it as last-granted.
REQ-005 If only one req is high, that requester SHALL win regardless of prio_mode.
REQ-006 If both reqs are high and prio_mode=0, the requester that is not last-granted SHALL win.
REQ-007 If both reqs are high and prio_mode=1, requester 0 SHALL win; last-granted still updates.
REQ-008 On the next edge in EXEC, the block SHALL:
- capture alu_f into res_f;
- pulse res_valid and set res_id to the winner;
- clear gnt;
- return to IDLE.
REQ-009 Latency SHALL be fixed: res_valid rises exactly one cycle after gnt rises; throughput is one operation per two cycles.
REQ-010 gnt0 and gnt1 SHALL never be high together; at most one of them is high, and only in EXEC.
REQ-011 alu_oc/alu_a/alu_b SHALL hold their last value until the next grant.
REQ-012 res_f and res_id SHALL hold until the next res_valid.
REQ-013 busy SHALL equal (state == EXEC).
REQ-014 Requester obligations: hold oc/a/b stable while req is high, and drop req by the edge after gnt falls. A req still high at that edge SHALL be treated as a new request.
REQ-015 A change of prio_mode SHALL take effect at the next IDLE arbitration, not mid-operation.

Reset
REQ-016 While rst_n is low, the block SHALL asynchronously force:
- state = IDLE;
- gnt0 = gnt1 = res_valid = busy = 0;
- alu_oc = 0, alu_a = 0, alu_b = 0, res_f = 0, res_id = 0;
- last-granted = 1, so requester 0 wins the first contested arbitration.
REQ-017 A reset asserted during EXEC SHALL abort the operation; no res_valid SHALL be produced for it.

Structure
REQ-018 A shared package alu_arb_pkg SHALL hold:
- OC_W=3, D_W=4;
- state encoding IDLE/EXEC;
- requester-id type.
REQ-019 Arbitration SHALL be a combinational sub-module arb_pick.
- Inputs: req0, req1, last, prio_mode.
- Outputs: any, winner.
- alu_arbiter instantiates it once.
REQ-020 The ALU itself SHALL NOT be instantiated inside alu_arbiter.

Verification
REQ-021 The bench SHALL instantiate alu_arbiter and the team's alu, connected through alu_*. It SHALL cover:
- Single request: req0=1, oc0=3'b000, a0=4'd3, b0=4'd5, req1=0 -> gnt0 pulses one cycle with alu_a=3, alu_b=5 -> next cycle res_valid=1, res_id=0, res_f equal to alu f for those inputs.
- Contention, round-robin: req0=req1=1 held, prio_mode=0 -> grant order 0,1,0,1 every two cycles, never both gnt high.
- Contention, fixed priority: req0=req1=1 held, prio_mode=1 -> only gnt0 pulses; gnt1 pulses once req0 drops.
- Reset in EXEC: rst_n low in the cycle gnt1 is high -> gnt1, busy, res_valid and alu_* go 0 immediately, no res_valid follows; after release, contested request grants 0 first.
- Idle: no req for 20 cycles -> busy=0, res_valid=0, alu_* unchanged.
- Random: 1000 random req/oc/a/b/prio_mode patterns -> every res_f matches an alu reference for the granted operands, and res_valid count equals grant count.
